// File: rtl/adder_accumulator_if.sv
// Handshake bundle between the nbits_adder result source, adder_accumulator and its consumer.
// master = environment (drives samples, accepts totals); slave = adder_accumulator.
interface adder_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 3
);
  logic                 in_clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sum;
  logic                 in_carry;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_acc;
  logic                 out_overflow;
  logic [CNT_WIDTH-1:0] out_count;

  modport master (
    output in_clear, in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_acc, out_overflow, out_count
  );

  modport slave (
    input  in_clear, in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_acc, out_overflow, out_count
  );
endinterface

// File: rtl/adder_accumulator.sv
// Accumulates BURST_LEN {carry,sum} samples and holds the total on a valid/ready output.
// Define ADDER_ACCUM_SATURATE_EN to clamp the total at all-ones instead of wrapping.
module adder_accumulator #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_accumulator_if.slave   bus
);
  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH:0]     sample;
  logic [ACC_WIDTH:0]     sum_full;
  logic                   accept;

  // Bit ACC_WIDTH of the untruncated sum marks an overflowing add.
  function automatic logic [ACC_WIDTH-1:0] acc_limit(input logic [ACC_WIDTH:0] s);
`ifdef ADDER_ACCUM_SATURATE_EN
    acc_limit = s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
    acc_limit = s[ACC_WIDTH-1:0];
`endif
  endfunction

  assign sample   = {{(ACC_WIDTH - WIDTH){1'b0}}, bus.in_carry, bus.in_sum};
  assign sum_full = {1'b0, acc_q} + sample;
  assign accept   = bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (bus.in_clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = acc_limit(sum_full);
            ovf_d = ovf_q | sum_full[ACC_WIDTH];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(BURST_LEN - 1)) begin
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          // Restart only after the consumer takes the total; input stays stalled meanwhile.
          if (bus.out_ready) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_acc      = acc_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_count    = cnt_q;
endmodule

// File: tb/tb_adder_accumulator.sv
// Directed-vector bench for adder_accumulator: a 16-bit instance plus a 10-bit one for overflow.
module tb_adder_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  adder_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(3)) ifa ();
  adder_accumulator_if #(.WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(3)) ifb ();

  adder_accumulator #(.WIDTH(8), .BURST_LEN(4), .ACC_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  adder_accumulator #(.WIDTH(8), .BURST_LEN(4), .ACC_WIDTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] s, input logic c);
    ifa.in_sum = s; ifa.in_carry = c; ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] s, input logic c);
    ifb.in_sum = s; ifb.in_carry = c; ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total_cnt++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.out_acc !== 16'd0 ||
        ifa.out_count !== 3'd0 || ifa.out_overflow !== 1'b0)
      $display("FAIL reset_state: got rdy=%0b vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 0 0 0 0",
               ifa.in_ready, ifa.out_valid, ifa.out_acc, ifa.out_count, ifa.out_overflow);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    ifa.out_ready = 1'b1;
    send_a(8'd0, 1'b0); send_a(8'd1, 1'b0); send_a(8'd2, 1'b0); send_a(8'd24, 1'b0);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd27 || ifa.out_overflow !== 1'b0 ||
        ifa.out_count !== 3'd4 || ifa.in_ready !== 1'b0)
      $display("FAIL basic_burst: got vld=%0b acc=%0d ovf=%0b cnt=%0d rdy=%0b want 1 27 0 4 0",
               ifa.out_valid, ifa.out_acc, ifa.out_overflow, ifa.out_count, ifa.in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_acc !== 16'd0 || ifa.out_count !== 3'd0)
      $display("FAIL basic_release: got vld=%0b rdy=%0b acc=%0d cnt=%0d want 0 1 0 0",
               ifa.out_valid, ifa.in_ready, ifa.out_acc, ifa.out_count);
    else pass_cnt++;
  endtask

  task automatic test_carry;
    ifa.out_ready = 1'b1;
    send_a(8'hFF, 1'b1); send_a(8'hFF, 1'b1);
    // Idle cycle with garbage data must not count as an accept.
    ifa.in_sum = 8'hFF; ifa.in_carry = 1'b1; ifa.in_valid = 1'b0;
    tick();
    total_cnt++;
    if (ifa.out_count !== 3'd2 || ifa.out_acc !== 16'd1022)
      $display("FAIL idle_no_accept: got cnt=%0d acc=%0d want 2 1022", ifa.out_count, ifa.out_acc);
    else pass_cnt++;
    send_a(8'hFF, 1'b1); send_a(8'hFF, 1'b1);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd2044 || ifa.out_overflow !== 1'b0)
      $display("FAIL carry_weight: got vld=%0b acc=%0d ovf=%0b want 1 2044 0",
               ifa.out_valid, ifa.out_acc, ifa.out_overflow);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_overflow;
    logic [9:0] exp_acc;
`ifdef ADDER_ACCUM_SATURATE_EN
    exp_acc = 10'd1023;
`else
    exp_acc = 10'd1020;
`endif
    ifb.out_ready = 1'b1;
    send_b(8'hFF, 1'b1); send_b(8'hFF, 1'b1); send_b(8'hFF, 1'b1); send_b(8'hFF, 1'b1);
    total_cnt++;
    if (ifb.out_valid !== 1'b1 || ifb.out_acc !== exp_acc || ifb.out_overflow !== 1'b1)
      $display("FAIL overflow_burst: got vld=%0b acc=%0d ovf=%0b want 1 %0d 1",
               ifb.out_valid, ifb.out_acc, ifb.out_overflow, exp_acc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ifb.out_overflow !== 1'b0 || ifb.out_acc !== 10'd0)
      $display("FAIL overflow_clear: got ovf=%0b acc=%0d want 0 0", ifb.out_overflow, ifb.out_acc);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    ifa.out_ready = 1'b0;
    send_a(8'd10, 1'b0); send_a(8'd20, 1'b0); send_a(8'd30, 1'b0); send_a(8'd40, 1'b0);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd100)
      $display("FAIL bp_complete: got vld=%0b acc=%0d want 1 100", ifa.out_valid, ifa.out_acc);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      ifa.in_sum = 8'd99; ifa.in_carry = 1'b1; ifa.in_valid = 1'b1;
      tick();
      total_cnt++;
      if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd100 || ifa.in_ready !== 1'b0 || ifa.out_count !== 3'd4)
        $display("FAIL bp_stall[%0d]: got vld=%0b acc=%0d rdy=%0b cnt=%0d want 1 100 0 4",
                 i, ifa.out_valid, ifa.out_acc, ifa.in_ready, ifa.out_count);
      else pass_cnt++;
    end
    ifa.in_valid = 1'b0; ifa.in_carry = 1'b0; ifa.out_ready = 1'b1;
    tick();
    total_cnt++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1)
      $display("FAIL bp_release: got vld=%0b rdy=%0b want 0 1", ifa.out_valid, ifa.in_ready);
    else pass_cnt++;
    send_a(8'd1, 1'b0); send_a(8'd2, 1'b0); send_a(8'd3, 1'b0); send_a(8'd4, 1'b0);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd10)
      $display("FAIL bp_next_burst: got vld=%0b acc=%0d want 1 10", ifa.out_valid, ifa.out_acc);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_clear;
    ifa.out_ready = 1'b1;
    send_a(8'd7, 1'b0); send_a(8'd7, 1'b0);
    ifa.in_clear = 1'b1; ifa.in_valid = 1'b1; ifa.in_sum = 8'd50;
    tick();
    ifa.in_clear = 1'b0; ifa.in_valid = 1'b0;
    total_cnt++;
    if (ifa.out_count !== 3'd0 || ifa.out_acc !== 16'd0 || ifa.in_ready !== 1'b1)
      $display("FAIL clear_partial: got cnt=%0d acc=%0d rdy=%0b want 0 0 1",
               ifa.out_count, ifa.out_acc, ifa.in_ready);
    else pass_cnt++;
    send_a(8'd5, 1'b0); send_a(8'd5, 1'b0); send_a(8'd5, 1'b0); send_a(8'd5, 1'b0);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd20 || ifa.out_count !== 3'd4)
      $display("FAIL clear_restart: got vld=%0b acc=%0d cnt=%0d want 1 20 4",
               ifa.out_valid, ifa.out_acc, ifa.out_count);
    else pass_cnt++;
    // Clear while holding, with out_ready high, must drop the total outright.
    ifa.in_clear = 1'b1;
    tick();
    ifa.in_clear = 1'b0;
    total_cnt++;
    if (ifa.out_valid !== 1'b0 || ifa.out_acc !== 16'd0 || ifa.in_ready !== 1'b1)
      $display("FAIL clear_hold: got vld=%0b acc=%0d rdy=%0b want 0 0 1",
               ifa.out_valid, ifa.out_acc, ifa.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    ifa.out_ready = 1'b1;
    send_a(8'd3, 1'b0); send_a(8'd3, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.out_acc !== 16'd0 ||
        ifa.out_count !== 3'd0 || ifa.out_overflow !== 1'b0)
      $display("FAIL reset_mid: got rdy=%0b vld=%0b acc=%0d cnt=%0d ovf=%0b want 1 0 0 0 0",
               ifa.in_ready, ifa.out_valid, ifa.out_acc, ifa.out_count, ifa.out_overflow);
    else pass_cnt++;
    send_a(8'd5, 1'b0); send_a(8'd5, 1'b0); send_a(8'd5, 1'b0); send_a(8'd5, 1'b0);
    total_cnt++;
    if (ifa.out_valid !== 1'b1 || ifa.out_acc !== 16'd20)
      $display("FAIL reset_restart: got vld=%0b acc=%0d want 1 20", ifa.out_valid, ifa.out_acc);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.in_clear = 1'b0; ifa.in_valid = 1'b0; ifa.in_sum = '0; ifa.in_carry = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_clear = 1'b0; ifb.in_valid = 1'b0; ifb.in_sum = '0; ifb.in_carry = 1'b0; ifb.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
